// File: rtl/apb_regfile.sv
// APB slave register file: read-only ID at index 0, NUM_REGS-1 R/W words, configurable wait states.
// Define APB_REGFILE_PSTRB_EN to honour pstrb byte lanes; otherwise every valid write updates the full word.
module apb_regfile #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA5B0_0001
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic                    do_access;
  logic [IDX_W-1:0]        idx;
  logic                    acc_err;
  logic [DATA_WIDTH-1:0]   cur_val, rd_val, wr_val;
  logic [DATA_WIDTH-1:0]   regs [1:NUM_REGS-1];
  logic [1:0]              unused_addr_lsb;

  assign idx             = paddr[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = paddr[1:0];

  // Out-of-range index, or any write aimed at the read-only ID word.
  assign acc_err = ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS)) || (pwrite && (idx == '0));

  always_comb begin
    cur_val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) cur_val = regs[i];
    end
  end

  assign rd_val = (idx == '0) ? ID_VALUE : cur_val;

`ifdef APB_REGFILE_PSTRB_EN
  always_comb begin
    wr_val = cur_val;
    for (int b = 0; b < NB; b++) begin
      if (pstrb[b]) wr_val[8*b +: 8] = pwdata[8*b +: 8];
    end
  end
`else
  logic [NB-1:0] unused_pstrb;
  assign unused_pstrb = pstrb;
  assign wr_val       = pwdata;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // do_access marks the edge that commits the transfer and loads the response.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (psel && penable) begin
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pready  <= do_access;
      pslverr <= do_access && acc_err;
      if (do_access) begin
        if (acc_err) begin
          prdata <= '0;
        end else if (!pwrite) begin
          prdata <= rd_val;
        end else begin
          for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) regs[i] <= wr_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile.sv
// Bench for apb_regfile: one instance with no wait states and one with three, sharing the bus wires.
// Directed vector table, randomized transfers against an array model, plus abort and mid-transfer reset.
module tb_apb_regfile;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          tgt;

  logic        psel0, psel3;
  logic [31:0] prdata0, prdata3, prdata_s;
  logic        pready0, pready3, pready_s;
  logic        pslverr0, pslverr3, pslverr_s;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [2][8];
  logic [31:0] last_rd [2];

  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_REGFILE_PSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'hFF00_FF00;
`else
  localparam logic [31:0] STRB_EXP = 32'h0000_0000;
`endif

  always #5 pclk = ~pclk;

  assign psel0     = psel && (tgt == 0);
  assign psel3     = psel && (tgt == 1);
  assign prdata_s  = (tgt == 0) ? prdata0  : prdata3;
  assign pready_s  = (tgt == 0) ? pready0  : pready3;
  assign pslverr_s = (tgt == 0) ? pslverr0 : pslverr3;

  apb_regfile #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_regfile #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Spec-level model: word index, error rule, byte-lane merge, prdata hold/clear.
  function automatic void model_xfer(input int d, input bit wr, input logic [7:0] addr,
                                     input logic [31:0] data, input logic [3:0] strb,
                                     output logic [31:0] erd, output logic eerr);
    int idx = int'(addr) / 4;
    eerr = (idx >= 8) || (wr && idx == 0);
    if (eerr) begin
      last_rd[d] = 32'h0;
    end else if (!wr) begin
      last_rd[d] = (idx == 0) ? ID : mem[d][idx];
    end else begin
      for (int b = 0; b < 4; b++) begin
`ifdef APB_REGFILE_PSTRB_EN
        if (strb[b]) mem[d][idx][8*b +: 8] = data[8*b +: 8];
`else
        mem[d][idx][8*b +: 8] = data[8*b +: 8];
`endif
      end
    end
    erd = last_rd[d];
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 32'h0;
      for (int i = 0; i < 8; i++) mem[d][i] = 32'h0;
    end
  endfunction

  task automatic applyStimulus(input int d, input bit wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [31:0] rd, output logic err, output int lat,
                               output int early);
    tgt = d;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge pclk);
    penable = 1'b1;
    lat = 0; early = 0; rd = 'x; err = 1'bx;
    do begin
      @(negedge pclk);
      lat++;
      if (pslverr_s && !pready_s) early++;
    end while (!pready_s && lat < 40);
    rd  = prdata_s;
    err = pslverr_s;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic xfer_check(input int d, input bit wr, input logic [7:0] addr,
                            input logic [31:0] data, input logic [3:0] strb, input string tag,
                            input bit use_tbl, input logic [31:0] t_rd, input logic t_err);
    logic [31:0] erd, rd;
    logic        eerr, err;
    int          lat, early;
    model_xfer(d, wr, addr, data, strb, erd, eerr);
    applyStimulus(d, wr, addr, data, strb, rd, err, lat, early);
    checkOutput({tag, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    checkOutput({tag, " pslverr"}, {31'b0, err}, {31'b0, use_tbl ? t_err : eerr});
    checkOutput({tag, " prdata"}, rd, (use_tbl && (!wr || t_err)) ? t_rd : erd);
    if (early != 0) checkOutput({tag, " pslverr without pready"}, 32'(early), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge pclk);
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    model_reset();
  endtask

  task automatic watch_no_ready(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge pclk);
      if (pready_s || pslverr_s) seen++;
    end
    checkOutput({tag, " stray pready"}, 32'(seen), 32'd0);
  endtask

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; tgt = 0;
    model_reset();

    vecs.push_back('{0, 8'h00, 32'h0, 4'h0, ID, 1'b0});
    for (int a = 4; a < 32; a += 4) vecs.push_back('{0, 8'(a), 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{0, 8'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1, 8'h20, 32'h12345678, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 8'h20, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{1, 8'h00, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 8'h00, 32'h0, 4'h0, ID, 1'b0});
    vecs.push_back('{0, 8'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1, 8'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1, 8'h04, 32'h00000000, 4'b0101, 32'h0, 1'b0});
    vecs.push_back('{0, 8'h06, 32'h0, 4'h0, STRB_EXP, 1'b0});

    repeat (2) @(negedge pclk);
    checkOutput("reset pready0", {31'b0, pready0}, 32'h0);
    checkOutput("reset pslverr0", {31'b0, pslverr0}, 32'h0);
    checkOutput("reset prdata0", prdata0, 32'h0);
    checkOutput("reset pready3", {31'b0, pready3}, 32'h0);
    checkOutput("reset prdata3", prdata3, 32'h0);
    presetn = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        xfer_check(d, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                   $sformatf("vec%0d/dut%0d", i, d), 1'b1, vecs[i].exp_rd, vecs[i].exp_err);
      end
    end

    for (int n = 0; n < 60; n++) begin
      int d = n % 2;
      logic [7:0] a = 8'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
      xfer_check(d, 1'($urandom), a, $urandom, 4'($urandom), $sformatf("rand%0d", n),
                 1'b0, 32'h0, 1'b0);
    end

    reset_pulse();
    tgt = 1;
    checkOutput("post-reset prdata3", prdata3, 32'h0);

    // Abort: psel dropped in the first wait cycle must not commit or respond.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    watch_no_ready("abort", 8);
    xfer_check(1, 1'b0, 8'h0C, 32'h0, 4'h0, "abort readback", 1'b1, 32'h0, 1'b0);

    xfer_check(1, 1'b1, 8'h10, 32'h77, 4'hF, "pre-reset write", 1'b0, 32'h0, 1'b0);
    xfer_check(1, 1'b0, 8'h10, 32'h0, 4'h0, "pre-reset read", 1'b1, 32'h77, 1'b0);

    // Reset lands in cycle A+2 of a write; nothing may commit.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    presetn = 1'b1;
    model_reset();
    watch_no_ready("midreset", 6);
    xfer_check(1, 1'b0, 8'h0C, 32'h0, 4'h0, "midreset reg3", 1'b1, 32'h0, 1'b0);
    xfer_check(1, 1'b0, 8'h10, 32'h0, 4'h0, "midreset reg4", 1'b1, 32'h0, 1'b0);
    xfer_check(0, 1'b0, 8'h00, 32'h0, 4'h0, "midreset id", 1'b1, ID, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
